forwarding_unit: RTL

Producer side of the EXE-stage operand forwarding interface. It tracks the destination registers of in-flight instructions and emits the registered forwarding selects (val1_sel, val2_sel, ST_val_sel) that steer the EXE stage's three operand muxes. It also raises a load-use stall toward the IF/ID registers. It sits between the ID stage and the ID/EXE pipeline register and keeps its own shadow copy of the EX/MEM/WB destination tags.

---
 rtl/forwarding_unit_pkg.sv | 46 ++++
 rtl/forwarding_unit_fwd_tag_reg.sv | 36 +++
 rtl/forwarding_unit.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/forwarding_unit_pkg.sv
// -----------------------------------------------------------------------------
// forwarding_unit_pkg
// Shared definitions for the EXE-stage operand forwarding unit:
//   REG_ADDR_LEN   register index width
//   FORW_SEL_LEN   forwarding select width
//   FORW_SEL_*     select encodings steering the EXE operand muxes
//   fwd_tag_t      in-flight destination tag {valid, dest, wbEn, memREn}
//   tagMatches     true when a source register is produced by a tag slot
//   pickSel        priority choice between an EX-slot and a MEM-slot hit
// -----------------------------------------------------------------------------
package forwarding_unit_pkg;

    localparam int REG_ADDR_LEN = 5;
    localparam int FORW_SEL_LEN = 2;

    localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_ID  = 2'd0;
    localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_MEM = 2'd1;
    localparam logic [FORW_SEL_LEN-1:0] FORW_SEL_WB  = 2'd2;

    typedef struct packed {
        logic                    valid;
        logic [REG_ADDR_LEN-1:0] dest;
        logic                    wbEn;
        logic                    memREn;
    } fwd_tag_t;

    // Register 0 is hardwired, so it never matches a producer.
    function automatic logic tagMatches(input fwd_tag_t tag,
                                        input logic [REG_ADDR_LEN-1:0] src);
        return tag.valid && tag.wbEn && (tag.dest == src) && (src != '0);
    endfunction

    // An EX-slot producer is newer than a MEM-slot one, so it wins. The EX-slot
    // instruction will be in MEM when the consumer reaches EXE, hence ALU_res_MEM;
    // the MEM-slot one will be in WB, hence result_WB.
    function automatic logic [FORW_SEL_LEN-1:0] pickSel(input logic exHit,
                                                        input logic memHit);
        if (exHit)
            return FORW_SEL_MEM;
        else if (memHit)
            return FORW_SEL_WB;
        else
            return FORW_SEL_ID;
    endfunction

endpackage

// File: rtl/forwarding_unit_fwd_tag_reg.sv
// -----------------------------------------------------------------------------
// fwd_tag_reg
// One slot of the shadow destination-tag pipeline.
// Ports:
//   clk       pipeline clock, rising edge
//   rst       asynchronous active-high reset, clears the slot
//   i_tag     tag arriving from the previous stage
//   i_bubble  load an empty (invalid) tag instead of i_tag
//   o_tag     registered tag held by this slot
// -----------------------------------------------------------------------------
module fwd_tag_reg
    import forwarding_unit_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  fwd_tag_t i_tag,
    input  logic     i_bubble,
    output fwd_tag_t o_tag
);

    fwd_tag_t r_tag;

    // A bubble clears the whole tag, not only valid, so stale dest bits never
    // linger in an empty slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tag <= '0;
        else if (i_bubble)
            r_tag <= '0;
        else
            r_tag <= i_tag;
    end

    assign o_tag = r_tag;

endmodule

// File: rtl/forwarding_unit.sv
// -----------------------------------------------------------------------------
// forwarding_unit
// Tracks destination tags of in-flight instructions (EX, MEM, WB slots) and
// produces the registered EXE forwarding selects plus a load-use stall.
// Build option: define FORWARDING_EN for forwarding; when it is undefined the
// unit is a full interlock (selects stay 0, stall on any EX/MEM producer).
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_valid                       ID holds a real instruction
//   id_src1, id_src2, id_st_src    source register indices
//   id_two_src                     val2 comes from id_src2 (else immediate)
//   id_is_store                    ST_value comes from id_st_src
//   id_dest, id_WB_EN, id_MEM_R_EN destination, writes back, is a load
//   flush                          taken branch, kill the ID instruction
//   val1_sel, val2_sel, ST_val_sel registered selects for the EXE instruction
//   hazard_stall                   combinational stall toward PC and IF/ID
// -----------------------------------------------------------------------------
module forwarding_unit
    import forwarding_unit_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic [REG_ADDR_LEN-1:0] id_st_src,
    input  logic                    id_two_src,
    input  logic                    id_is_store,
    input  logic [REG_ADDR_LEN-1:0] id_dest,
    input  logic                    id_WB_EN,
    input  logic                    id_MEM_R_EN,
    input  logic                    flush,
    output logic [FORW_SEL_LEN-1:0] val1_sel,
    output logic [FORW_SEL_LEN-1:0] val2_sel,
    output logic [FORW_SEL_LEN-1:0] ST_val_sel,
    output logic                    hazard_stall
);

    fwd_tag_t w_idTag;
    fwd_tag_t w_exTag;
    fwd_tag_t w_memTag;
    fwd_tag_t w_wbTagUnused;
    logic     w_idBubble;
    logic     w_src1Ex, w_src2Ex, w_stEx;
    logic     w_src1Mem, w_src2Mem, w_stMem;
    logic     w_anyEx;

    always_comb begin
        w_idTag        = '0;
        w_idTag.valid  = 1'b1;
        w_idTag.dest   = id_dest;
        w_idTag.wbEn   = id_WB_EN;
        w_idTag.memREn = id_MEM_R_EN;
    end

    // A stalled or flushed ID instruction must not be recorded as in flight.
    assign w_idBubble = ~id_valid | hazard_stall | flush;

    fwd_tag_reg u_exSlot (
        .clk      (clk),
        .rst      (rst),
        .i_tag    (w_idTag),
        .i_bubble (w_idBubble),
        .o_tag    (w_exTag)
    );

    fwd_tag_reg u_memSlot (
        .clk      (clk),
        .rst      (rst),
        .i_tag    (w_exTag),
        .i_bubble (1'b0),
        .o_tag    (w_memTag)
    );

    // The register file writes before it reads, so the WB slot never feeds a
    // decision; it is kept so the shadow pipeline mirrors the real one.
    fwd_tag_reg u_wbSlot (
        .clk      (clk),
        .rst      (rst),
        .i_tag    (w_memTag),
        .i_bubble (1'b0),
        .o_tag    (w_wbTagUnused)
    );

    assign w_src1Ex  = tagMatches(w_exTag, id_src1);
    assign w_src2Ex  = tagMatches(w_exTag, id_src2);
    assign w_stEx    = tagMatches(w_exTag, id_st_src);
    assign w_src1Mem = tagMatches(w_memTag, id_src1);
    assign w_src2Mem = tagMatches(w_memTag, id_src2);
    assign w_stMem   = tagMatches(w_memTag, id_st_src);

    // Only sources the instruction actually reads can create a hazard.
    assign w_anyEx = w_src1Ex | (id_two_src & w_src2Ex) | (id_is_store & w_stEx);

`ifdef FORWARDING_EN

    logic [FORW_SEL_LEN-1:0] w_val1Sel, w_val2Sel, w_stValSel;
    logic [FORW_SEL_LEN-1:0] r_val1Sel, r_val2Sel, r_stValSel;

    // A load's data is only available after MEM, so an EX-slot load cannot be
    // forwarded yet; one stall moves it into MEM where WB forwarding applies.
    assign hazard_stall = id_valid & ~flush & w_anyEx & w_exTag.memREn;

    always_comb begin
        w_val1Sel  = pickSel(w_src1Ex, w_src1Mem);
        w_val2Sel  = FORW_SEL_ID;
        w_stValSel = FORW_SEL_ID;
        if (id_two_src)
            w_val2Sel = pickSel(w_src2Ex, w_src2Mem);
        if (id_is_store)
            w_stValSel = pickSel(w_stEx, w_stMem);
    end

    // The selects travel with the instruction into EXE; bubbles carry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val1Sel  <= FORW_SEL_ID;
            r_val2Sel  <= FORW_SEL_ID;
            r_stValSel <= FORW_SEL_ID;
        end else if (w_idBubble) begin
            r_val1Sel  <= FORW_SEL_ID;
            r_val2Sel  <= FORW_SEL_ID;
            r_stValSel <= FORW_SEL_ID;
        end else begin
            r_val1Sel  <= w_val1Sel;
            r_val2Sel  <= w_val2Sel;
            r_stValSel <= w_stValSel;
        end
    end

    assign val1_sel   = r_val1Sel;
    assign val2_sel   = r_val2Sel;
    assign ST_val_sel = r_stValSel;

`else

    logic w_anyMem;

    // Without forwarding the consumer waits until the producer reaches WB.
    assign w_anyMem = w_src1Mem | (id_two_src & w_src2Mem) | (id_is_store & w_stMem);

    assign hazard_stall = id_valid & ~flush & (w_anyEx | w_anyMem);

    assign val1_sel   = FORW_SEL_ID;
    assign val2_sel   = FORW_SEL_ID;
    assign ST_val_sel = FORW_SEL_ID;

`endif

endmodule
